// File: rtl/seq_mult_cla_16_pkg.sv
// Shared constants and state type for the sequential CLA-based multiplier.
//   N_BITS : operand width (the adder is fixed at 16 bits)
//   CNT_W  : iteration counter width, wide enough to hold N_BITS
//   state_t: controller states IDLE / BUSY / DONE
package seq_mult_cla_16_pkg;

  localparam int N_BITS = 16;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_cla_16_cla.sv
// cla_16_bit: 16-bit adder built from four 4-bit groups with a carry
// look-ahead unit across the groups.
//   a, b  : 16-bit addends
//   c_in  : carry in
//   sum   : 16-bit sum
//   c_out : carry out
//   p, g  : block propagate / generate of the whole 16-bit word
module cla_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        p,
  output logic        g
);

  logic [15:0] pb;
  logic [15:0] gb;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;
  logic [16:0] c;

  assign pb = a ^ b;
  assign gb = a & b;

  always_comb begin
    gp = '0;
    gg = '0;
    for (int i = 0; i < 4; i++) begin
      gp[i] = &pb[4*i +: 4];
      gg[i] = gb[4*i+3]
            | (pb[4*i+3] & gb[4*i+2])
            | (pb[4*i+3] & pb[4*i+2] & gb[4*i+1])
            | (pb[4*i+3] & pb[4*i+2] & pb[4*i+1] & gb[4*i]);
    end
  end

  // Group carries resolved in parallel from c_in rather than rippled.
  always_comb begin
    gc    = '0;
    gc[0] = c_in;
    gc[1] = gg[0] | (gp[0] & c_in);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c_in);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i] = gc[i];
      for (int j = 0; j < 3; j++) begin
        c[4*i+j+1] = gb[4*i+j] | (pb[4*i+j] & c[4*i+j]);
      end
    end
    c[16] = gc[4];
  end

  assign sum   = pb ^ c[15:0];
  assign c_out = gc[4];
  assign p     = &gp;
  assign g     = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]);

endmodule

// File: rtl/seq_mult_cla_16.sv
// seq_mult_cla_16: 16x16 unsigned shift-and-add multiplier, one conditional
// add plus one right shift per cycle through cla_16_bit.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, only looked at in IDLE
//   a, b     : multiplicand / multiplier, captured with an accepted start
//   busy     : high for the 16 iteration cycles
//   done     : one-cycle pulse when product is updated
//   product  : 32-bit result, held until the next completion
//
//   state | meaning
//   IDLE  | waiting for start
//   BUSY  | iterating, count holds remaining iterations
//   DONE  | product valid, done pulse, returns to IDLE
module seq_mult_cla_16
  import seq_mult_cla_16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        acc;
  logic [15:0]        q;
  logic [15:0]        m;
  logic [15:0]        addend;
  logic [15:0]        sum;
  logic               carry;
  logic [CNT_W-1:0]   count;
  logic [31:0]        shifted;
  logic               cla_p_unused;
  logic               cla_g_unused;

  assign addend = q[0] ? m : 16'd0;

  cla_16_bit u_cla (
    .a     (acc),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (carry),
    .p     (cla_p_unused),
    .g     (cla_g_unused)
  );

  // The adder carry becomes the new ACC MSB, so the 32-bit result is exact.
  assign shifted = {carry, sum, q[15:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (count == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            count <= CNT_W'(N_BITS);
          end
        end
        BUSY: begin
          {acc, q} <= shifted;
          count    <= count - CNT_W'(1);
          if (count == CNT_W'(1)) product <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mult_cla_16.sv
module tb_seq_mult_cla_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  always #5 clk = ~clk;

  seq_mult_cla_16 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] sb[$];
  logic [31:0] prev_product = 32'd0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  function automatic logic [31:0] sb_pop();
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
      return 32'hxxxx_xxxx;
    end
    return sb.pop_front();
  endfunction

  // One operation; optional ignored start pulse at iteration inj.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input int inj, input string nm);
    int   n;
    bit   seen;
    bit   stable;
    logic [31:0] exp;
    n = 0; seen = 0; stable = 1;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    sb.push_back(32'(va) * 32'(vb));
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (inj != 0 && n == inj) begin start = 1'b1; a = 16'd1; b = 16'd1; end
      if (inj != 0 && n == inj + 1) start = 1'b0;
      if (done) seen = 1;
      else if (product !== prev_product || busy !== 1'b1) stable = 0;
      if (busy && done) stable = 0;
    end
    exp = sb_pop();
    check({nm, "_done_seen"}, 64'(seen), 64'd1);
    check({nm, "_latency"}, 64'(n), 64'd17);
    check({nm, "_product"}, 64'(product), 64'(exp));
    check({nm, "_busy_stable"}, 64'(stable), 64'd1);
    prev_product = exp;
    @(negedge clk);
    check({nm, "_done_one_cycle"}, 64'({busy, done}), 64'd0);
  endtask

  // One operation interrupted by rst at iteration rst_at.
  task automatic run_rst_op(input logic [15:0] va, input logic [15:0] vb, input int rst_at);
    int n;
    int dones;
    logic [31:0] discard;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    sb.push_back(32'(va) * 32'(vb));
    for (n = 1; n <= rst_at; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_product", 64'(product), 64'd0);
    discard = sb_pop();
    prev_product = 32'd0;
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_mid_no_done", 64'(dones), 64'd0);
  endtask

  // start held high across several operand pairs.
  task automatic run_held();
    logic [15:0] pa[3];
    logic [15:0] pb[3];
    logic [31:0] exp;
    int          n;
    int          last;
    bit          seen;
    bit          stable;
    pa[0] = 16'd300;   pb[0] = 16'd700;
    pa[1] = 16'd65535; pb[1] = 16'd2;
    pa[2] = 16'd4321;  pb[2] = 16'd1234;
    @(negedge clk);
    a = pa[0]; b = pb[0]; start = 1'b1;
    sb.push_back(32'(pa[0]) * 32'(pb[0]));
    n = 0; last = 0;
    for (int k = 0; k < 3; k++) begin
      seen = 0; stable = 1;
      while (!seen && n < 200) begin
        @(negedge clk);
        n++;
        if (done) seen = 1;
        else if (product !== prev_product) stable = 0;
      end
      exp = sb_pop();
      check("held_done_seen", 64'(seen), 64'd1);
      check("held_product", 64'(product), 64'(exp));
      check("held_stable", 64'(stable), 64'd1);
      if (k == 0) check("held_first_latency", 64'(n), 64'd17);
      else        check("held_period", 64'(n - last), 64'd18);
      last = n;
      prev_product = exp;
      if (k < 2) begin
        a = pa[k+1]; b = pb[k+1];
        sb.push_back(32'(pa[k+1]) * 32'(pb[k+1]));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("held_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'd414,   16'd1036,  32'd428904};
    vecs[1] = '{16'd65535, 16'd65535, 32'hFFFE0001};
    vecs[2] = '{16'd32768, 16'd32768, 32'd1073741824};
    vecs[3] = '{16'd0,     16'd5045,  32'd0};
    vecs[4] = '{16'd1,     16'd1,     32'd1};
    vecs[5] = '{16'd65535, 16'd1,     32'd65535};
    vecs[6] = '{16'd12345, 16'd6789,  32'd83810205};
    vecs[7] = '{16'd5045,  16'd0,     32'd0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);

    // rst and start on the same edge: reset wins
    start = 1'b1; a = 16'd7; b = 16'd9;
    @(negedge clk);
    check("rst_start_same_edge", 64'(busy), 64'd0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      check("table_model", 64'(32'(vecs[i].va) * 32'(vecs[i].vb)), 64'(vecs[i].exp));
      run_op(vecs[i].va, vecs[i].vb, 0, "table");
      check("table_expected", 64'(product), 64'(vecs[i].exp));
    end

    for (int i = 0; i < 4; i++) begin
      run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 0, "rand");
    end

    run_op(16'd5045, 16'd45042, 5, "ignored_start");
    check("ignored_start_value", 64'(product), 64'd227236890);
    begin
      int extra = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("ignored_start_no_second_op", 64'(extra), 64'd0);
    end

    run_rst_op(16'd414, 16'd1036, 8);

    run_held();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
